// File: rtl/sync_wconv_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_wconv_fifo
//  Purpose  : Single-clock FIFO with width conversion. It packs narrow beats
//             into wide words (upsize) or unpacks wide words into narrow
//             slices (downsize). It supports packet boundaries through last
//             and marks valid output lanes with a keep mask.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_wconv_fifo #(
    parameter int    IN_DATA_WIDTH  = 32,
    parameter int    OUT_DATA_WIDTH = 128,
    parameter int    FIFO_DEPTH     = 8,
    parameter string CONCAT_ORDER   = "LSB",
    parameter int    ADDR_WIDTH     = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_DATA_WIDTH-1:0]  data_i,
    input  logic                      last_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    output logic [OUT_DATA_WIDTH-1:0] data_o,
    output logic [OUT_DATA_WIDTH/((IN_DATA_WIDTH < OUT_DATA_WIDTH) ? IN_DATA_WIDTH : OUT_DATA_WIDTH)-1:0] keep_o,
    output logic                      last_o,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [ADDR_WIDTH:0]       counter
);

    localparam int C_MAX_W   = (IN_DATA_WIDTH > OUT_DATA_WIDTH) ? IN_DATA_WIDTH : OUT_DATA_WIDTH;
    localparam int C_MIN_W   = (IN_DATA_WIDTH < OUT_DATA_WIDTH) ? IN_DATA_WIDTH : OUT_DATA_WIDTH;
    localparam int C_RATIO   = C_MAX_W / C_MIN_W;
    localparam int C_LANES   = OUT_DATA_WIDTH / C_MIN_W;
    localparam int C_CNT_W   = (C_RATIO > 1) ? $clog2(C_RATIO) : 1;
    localparam bit C_UPSIZE    = (OUT_DATA_WIDTH > IN_DATA_WIDTH);
    localparam bit C_DOWNSIZE  = (IN_DATA_WIDTH > OUT_DATA_WIDTH);
    localparam bit C_MSB_FIRST = (CONCAT_ORDER == "MSB");
    localparam logic [C_CNT_W-1:0]  C_LAST_LANE = C_CNT_W'(C_RATIO - 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [ADDR_WIDTH:0] C_PTR_ONE   = (ADDR_WIDTH + 1)'(1);

    // Storage: one wide word, its lane mask and its packet-end flag per entry
    logic [C_MAX_W-1:0]  r_mem_data [FIFO_DEPTH];
    logic [C_LANES-1:0]  r_mem_keep [FIFO_DEPTH];
    logic                r_mem_last [FIFO_DEPTH];

    logic [ADDR_WIDTH:0]     r_wr_ptr;
    logic [ADDR_WIDTH:0]     r_rd_ptr;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_hs;
    logic                    w_rd_hs;
    logic                    w_push;
    logic                    w_pop;
    logic [C_MAX_W-1:0]      w_push_data;
    logic [C_LANES-1:0]      w_push_keep;
    logic                    w_push_last;
    logic [C_MAX_W-1:0]      w_head_data;
    logic [C_LANES-1:0]      w_head_keep;
    logic                    w_head_last;
    logic [OUT_DATA_WIDTH-1:0] w_out_data;
    logic                    w_out_last;

    // Occupancy flags from wrap-bit pointers; writes never look at the read side
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                  (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
        w_wr_hs = wr_valid_i & ~w_full;
        w_rd_hs = rd_valid_i & ~w_empty;
    end

    // Head-of-queue entry, read asynchronously from storage
    always_comb begin
        w_head_data = r_mem_data[r_rd_ptr[ADDR_WIDTH-1:0]];
        w_head_keep = r_mem_keep[r_rd_ptr[ADDR_WIDTH-1:0]];
        w_head_last = r_mem_last[r_rd_ptr[ADDR_WIDTH-1:0]];
    end

    generate
        if (C_UPSIZE) begin : g_upsize
            logic [C_CNT_W-1:0]        r_wcnt;
            logic [OUT_DATA_WIDTH-1:0] r_asm;
            logic [C_CNT_W-1:0]        w_pos;
            logic [OUT_DATA_WIDTH-1:0] w_lane_data;
            logic                      w_word_done;

            // Place the beat in its lane; MSB order fills from the top lane downward
            always_comb begin
                w_pos       = C_MSB_FIRST ? (C_LAST_LANE - r_wcnt) : r_wcnt;
                w_word_done = (r_wcnt == C_LAST_LANE) | last_i;
                w_lane_data = '0;
                w_push_keep = '0;
                for (int s = 0; s < C_LANES; s++) begin
                    if (w_pos == C_CNT_W'(s)) begin
                        w_lane_data[s*IN_DATA_WIDTH +: IN_DATA_WIDTH] = data_i;
                    end
                    // keep bit s describes physical lane s of data_o
                    if (C_MSB_FIRST) begin
                        w_push_keep[s] = ((C_LANES - 1 - s) <= int'(r_wcnt));
                    end else begin
                        w_push_keep[s] = (s <= int'(r_wcnt));
                    end
                end
                w_push_data = r_asm | w_lane_data;
                w_push_last = last_i;
                w_push      = w_wr_hs & w_word_done;
                w_pop       = w_rd_hs;
                w_out_data  = w_head_data;
                w_out_last  = w_head_last;
            end

            // Lane counter and assembly register; cleared whenever a word is pushed
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wcnt <= '0;
                    r_asm  <= '0;
                end else if (w_wr_hs) begin
                    if (w_word_done) begin
                        r_wcnt <= '0;
                        r_asm  <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + C_CNT_ONE;
                        r_asm  <= w_push_data;
                    end
                end
            end
        end else if (C_DOWNSIZE) begin : g_downsize
            logic [C_CNT_W-1:0] r_rcnt;
            logic               w_slice_last;

            // Present slice rcnt of the head word; only the final slice pops the entry
            always_comb begin
                w_slice_last = (r_rcnt == C_LAST_LANE);
                w_push       = w_wr_hs;
                w_push_data  = data_i;
                w_push_keep  = '1;
                w_push_last  = last_i;
                w_pop        = w_rd_hs & w_slice_last;
                w_out_last   = w_head_last & w_slice_last;
                w_out_data   = '0;
                for (int s = 0; s < C_RATIO; s++) begin
                    if (r_rcnt == C_CNT_W'(s)) begin
                        w_out_data = w_head_data[s*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
                    end
                end
            end

            // Read slice counter, wraps after the last slice of each entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rcnt <= '0;
                end else if (w_rd_hs) begin
                    r_rcnt <= w_slice_last ? '0 : (r_rcnt + C_CNT_ONE);
                end
            end
        end else begin : g_plain
            // Equal widths: one beat in, one beat out
            always_comb begin
                w_push      = w_wr_hs;
                w_push_data = data_i;
                w_push_keep = '1;
                w_push_last = last_i;
                w_pop       = w_rd_hs;
                w_out_data  = w_head_data;
                w_out_last  = w_head_last;
            end
        end
    endgenerate

    // Storage write; contents need no reset because empty masks the outputs
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_push_data;
            r_mem_keep[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_push_keep;
            r_mem_last[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_push_last;
        end
    end

    // Write and read pointers, each with a wrap bit above the address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // Output view; data, keep and last read as zero while nothing is stored
    always_comb begin
        wr_ready_o = ~w_full;
        rd_ready_o = ~w_empty;
        empty_o    = w_empty;
        full_o     = w_full;
        counter    = r_wr_ptr - r_rd_ptr;
        data_o     = w_empty ? '0   : w_out_data;
        keep_o     = w_empty ? '0   : w_head_keep;
        last_o     = w_empty ? 1'b0 : w_out_last;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_wconv_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_wconv_fifo
//  Purpose  : Self-checking bench for sync_wconv_fifo: upsize LSB/MSB,
//             downsize and equal-width instances, table vectors, corner
//             sequences and randomized traffic against queue models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_wconv_fifo;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Upsize 32->128, LSB first
    logic [31:0]  u_din;  logic u_last, u_wv, u_wr, u_rv, u_rr, u_empty, u_full, u_lo;
    logic [127:0] u_dout; logic [3:0] u_keep; logic [3:0] u_cnt;
    // Upsize 32->128, MSB first
    logic [31:0]  m_din;  logic m_last, m_wv, m_wr, m_rv, m_rr, m_empty, m_full, m_lo;
    logic [127:0] m_dout; logic [3:0] m_keep; logic [3:0] m_cnt;
    // Downsize 128->32
    logic [127:0] d_din;  logic d_last, d_wv, d_wr, d_rv, d_rr, d_empty, d_full, d_lo;
    logic [31:0]  d_dout; logic [0:0] d_keep; logic [3:0] d_cnt;
    // Equal width 32->32
    logic [31:0]  p_din;  logic p_last, p_wv, p_wr, p_rv, p_rr, p_empty, p_full, p_lo;
    logic [31:0]  p_dout; logic [0:0] p_keep; logic [3:0] p_cnt;

    sync_wconv_fifo #(.IN_DATA_WIDTH(32), .OUT_DATA_WIDTH(128), .FIFO_DEPTH(8), .CONCAT_ORDER("LSB")) u_up (
        .clk(clk), .rst_n(rst_n), .data_i(u_din), .last_i(u_last), .wr_valid_i(u_wv), .wr_ready_o(u_wr),
        .data_o(u_dout), .keep_o(u_keep), .last_o(u_lo), .rd_valid_i(u_rv), .rd_ready_o(u_rr),
        .empty_o(u_empty), .full_o(u_full), .counter(u_cnt));
    sync_wconv_fifo #(.IN_DATA_WIDTH(32), .OUT_DATA_WIDTH(128), .FIFO_DEPTH(8), .CONCAT_ORDER("MSB")) u_msb (
        .clk(clk), .rst_n(rst_n), .data_i(m_din), .last_i(m_last), .wr_valid_i(m_wv), .wr_ready_o(m_wr),
        .data_o(m_dout), .keep_o(m_keep), .last_o(m_lo), .rd_valid_i(m_rv), .rd_ready_o(m_rr),
        .empty_o(m_empty), .full_o(m_full), .counter(m_cnt));
    sync_wconv_fifo #(.IN_DATA_WIDTH(128), .OUT_DATA_WIDTH(32), .FIFO_DEPTH(8), .CONCAT_ORDER("LSB")) u_dn (
        .clk(clk), .rst_n(rst_n), .data_i(d_din), .last_i(d_last), .wr_valid_i(d_wv), .wr_ready_o(d_wr),
        .data_o(d_dout), .keep_o(d_keep), .last_o(d_lo), .rd_valid_i(d_rv), .rd_ready_o(d_rr),
        .empty_o(d_empty), .full_o(d_full), .counter(d_cnt));
    sync_wconv_fifo #(.IN_DATA_WIDTH(32), .OUT_DATA_WIDTH(32), .FIFO_DEPTH(8), .CONCAT_ORDER("LSB")) u_pl (
        .clk(clk), .rst_n(rst_n), .data_i(p_din), .last_i(p_last), .wr_valid_i(p_wv), .wr_ready_o(p_wr),
        .data_o(p_dout), .keep_o(p_keep), .last_o(p_lo), .rd_valid_i(p_rv), .rd_ready_o(p_rr),
        .empty_o(p_empty), .full_o(p_full), .counter(p_cnt));

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic         wv;
        logic [31:0]  din;
        logic         last;
        logic         rv;
        logic [127:0] xd;
        logic [3:0]   xk;
        logic         xl;
        logic         xe;
        logic [3:0]   xc;
    } vec_t;
    vec_t tbl [11];

    typedef struct { logic [127:0] data; logic [3:0] keep; logic last; } uw_t;
    typedef struct { logic [31:0] data; logic last; } beat_t;
    uw_t   uq[$];
    logic [31:0] upend[$];
    beat_t dq[$];
    beat_t pq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_up();
        logic [127:0] xd;
        logic [3:0]   xk;
        logic         xl;
        xd = '0; xk = '0; xl = 1'b0;
        if (uq.size() > 0) begin
            xd = uq[0].data; xk = uq[0].keep; xl = uq[0].last;
        end
        chk("up_data",  u_dout, xd);
        chk("up_keep",  128'(u_keep), 128'(xk));
        chk("up_last",  128'(u_lo), 128'(xl));
        chk("up_cnt",   128'(u_cnt), 128'(uq.size()));
        chk("up_empty", 128'(u_empty), 128'(uq.size() == 0));
        chk("up_full",  128'(u_full), 128'(uq.size() == 8));
        chk("up_wrdy",  128'(u_wr), 128'(uq.size() != 8));
        chk("up_rrdy",  128'(u_rr), 128'(uq.size() != 0));
    endtask

    task automatic chk_dn();
        int ent;
        ent = (dq.size() + 3) / 4;
        chk("dn_data",  128'(d_dout), (dq.size() > 0) ? 128'(dq[0].data) : 128'(0));
        chk("dn_last",  128'(d_lo), (dq.size() > 0) ? 128'(dq[0].last) : 128'(0));
        chk("dn_keep",  128'(d_keep), 128'(dq.size() > 0));
        chk("dn_cnt",   128'(d_cnt), 128'(ent));
        chk("dn_empty", 128'(d_empty), 128'(dq.size() == 0));
        chk("dn_full",  128'(d_full), 128'(ent == 8));
        chk("dn_wrdy",  128'(d_wr), 128'(ent != 8));
    endtask

    task automatic chk_pl();
        chk("pl_data",  128'(p_dout), (pq.size() > 0) ? 128'(pq[0].data) : 128'(0));
        chk("pl_last",  128'(p_lo), (pq.size() > 0) ? 128'(pq[0].last) : 128'(0));
        chk("pl_keep",  128'(p_keep), 128'(pq.size() > 0));
        chk("pl_cnt",   128'(p_cnt), 128'(pq.size()));
        chk("pl_full",  128'(p_full), 128'(pq.size() == 8));
    endtask

    task automatic pl_step();
        bit wa, ra;
        wa = p_wv && (pq.size() < 8);
        ra = p_rv && (pq.size() > 0);
        tick();
        if (ra) void'(pq.pop_front());
        if (wa) pq.push_back('{p_din, p_last});
        chk_pl();
    endtask

    initial begin : main
        bit    fill, uwa, ura, dwa, dra;
        uw_t   w;
        u_din = '0; u_last = 0; u_wv = 0; u_rv = 0;
        m_din = '0; m_last = 0; m_wv = 0; m_rv = 0;
        d_din = '0; d_last = 0; d_wv = 0; d_rv = 0;
        p_din = '0; p_last = 0; p_wv = 0; p_rv = 0;

        tbl[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 128'h0, 4'h0, 1'b0, 1'b1, 4'd0};
        tbl[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 128'h0, 4'h0, 1'b0, 1'b1, 4'd0};
        tbl[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 128'h0, 4'h0, 1'b0, 1'b1, 4'd0};
        tbl[3]  = '{1'b1, 32'h44, 1'b0, 1'b0, 128'h00000044_00000033_00000022_00000011, 4'hF, 1'b0, 1'b0, 4'd1};
        tbl[4]  = '{1'b1, 32'hA,  1'b0, 1'b0, 128'h00000044_00000033_00000022_00000011, 4'hF, 1'b0, 1'b0, 4'd1};
        tbl[5]  = '{1'b1, 32'hB,  1'b1, 1'b0, 128'h00000044_00000033_00000022_00000011, 4'hF, 1'b0, 1'b0, 4'd2};
        tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 128'h0000000B_0000000A, 4'h3, 1'b1, 1'b0, 4'd1};
        tbl[7]  = '{1'b1, 32'hC,  1'b1, 1'b0, 128'h0000000B_0000000A, 4'h3, 1'b1, 1'b0, 4'd2};
        tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 128'h0000000C, 4'h1, 1'b1, 1'b0, 4'd1};
        tbl[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 128'h0, 4'h0, 1'b0, 1'b1, 4'd0};
        tbl[10] = '{1'b1, 32'h55, 1'b0, 1'b1, 128'h0, 4'h0, 1'b0, 1'b1, 4'd0};

        // Outputs held in reset
        #1;
        chk("rst_wrdy",  128'(u_wr), 128'(1));
        chk("rst_rrdy",  128'(u_rr), 128'(0));
        chk("rst_empty", 128'(u_empty), 128'(1));
        chk("rst_full",  128'(u_full), 128'(0));
        chk("rst_cnt",   128'(u_cnt), 128'(0));
        chk("rst_data",  u_dout, 128'(0));
        chk("rst_keep",  128'(u_keep), 128'(0));
        chk("rst_last",  128'(u_lo), 128'(0));
        chk("rst_dn_empty", 128'(d_empty), 128'(1));
        #2 rst_n = 1'b1;

        // Table vectors on the LSB upsize instance
        for (int i = 0; i < 11; i++) begin
            u_wv = tbl[i].wv; u_din = tbl[i].din; u_last = tbl[i].last; u_rv = tbl[i].rv;
            tick();
            chk($sformatf("tbl%0d_data", i),  u_dout, tbl[i].xd);
            chk($sformatf("tbl%0d_keep", i),  128'(u_keep), 128'(tbl[i].xk));
            chk($sformatf("tbl%0d_last", i),  128'(u_lo), 128'(tbl[i].xl));
            chk($sformatf("tbl%0d_empty", i), 128'(u_empty), 128'(tbl[i].xe));
            chk($sformatf("tbl%0d_rrdy", i),  128'(u_rr), 128'(!tbl[i].xe));
            chk($sformatf("tbl%0d_cnt", i),   128'(u_cnt), 128'(tbl[i].xc));
        end
        u_wv = 0; u_rv = 0; u_last = 0;

        // MSB-first packing
        m_wv = 1;
        for (int i = 0; i < 4; i++) begin
            m_din = 32'h11 * (i + 1);
            tick();
            if (i == 2) chk("msb_not_yet", 128'(m_empty), 128'(1));
        end
        m_wv = 0;
        chk("msb_data", m_dout, 128'h00000011_00000022_00000033_00000044);
        chk("msb_keep", 128'(m_keep), 128'(4'hF));
        chk("msb_cnt",  128'(m_cnt), 128'(1));
        m_rv = 1; tick(); m_rv = 0;
        chk("msb_empty", 128'(m_empty), 128'(1));

        // Downsize unpacking with rd_valid held high
        d_din = 128'h44444444_33333333_22222222_11111111; d_last = 1; d_wv = 1;
        tick();
        d_wv = 0; d_last = 0;
        chk("dn_s0", 128'(d_dout), 128'h11111111);
        chk("dn_s0_last", 128'(d_lo), 128'(0));
        chk("dn_s0_cnt", 128'(d_cnt), 128'(1));
        d_rv = 1;
        tick(); chk("dn_s1", 128'(d_dout), 128'h22222222); chk("dn_s1_last", 128'(d_lo), 128'(0));
        tick(); chk("dn_s2", 128'(d_dout), 128'h33333333); chk("dn_s2_last", 128'(d_lo), 128'(0));
        tick(); chk("dn_s3", 128'(d_dout), 128'h44444444); chk("dn_s3_last", 128'(d_lo), 128'(1));
        chk("dn_s3_keep", 128'(d_keep), 128'(1));
        tick(); chk("dn_end_empty", 128'(d_empty), 128'(1)); chk("dn_end_data", 128'(d_dout), 128'(0));
        d_rv = 0;

        // Full, ignored write, read with blocked write, then wrap traffic
        p_wv = 1;
        for (int i = 0; i < 9; i++) begin
            p_din = 32'h100 + i; p_last = i[0];
            pl_step();
        end
        chk("pl_cnt_full", 128'(p_cnt), 128'(8));
        chk("pl_wrdy_full", 128'(p_wr), 128'(0));
        p_din = 32'hBEEF; p_rv = 1;
        pl_step();
        chk("pl_cnt_rw", 128'(p_cnt), 128'(7));
        for (int i = 0; i < 20; i++) begin
            p_wv = (i % 3) != 2; p_rv = (i % 4) != 3;
            p_din = 32'h200 + i; p_last = i[1];
            pl_step();
        end
        p_wv = 0; p_rv = 1;
        for (int i = 0; i < 12; i++) pl_step();
        chk("pl_drained", 128'(p_empty), 128'(1));
        p_rv = 0;

        // Reset in the middle of a partially assembled word
        u_wv = 1;
        u_din = 32'h66; tick();
        u_din = 32'h77; tick();
        u_din = 32'h88; tick();
        chk("pre_rst_data", u_dout, 128'h00000088_00000077_00000066_00000055);
        chk("pre_rst_cnt", 128'(u_cnt), 128'(1));
        u_din = 32'h99; tick();
        u_din = 32'hAA; tick();
        u_wv = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_empty", 128'(u_empty), 128'(1));
        chk("midrst_cnt",   128'(u_cnt), 128'(0));
        chk("midrst_data",  u_dout, 128'(0));
        #2 rst_n = 1'b1;
        u_wv = 1;
        for (int i = 1; i <= 4; i++) begin
            u_din = 32'(i); tick();
        end
        u_wv = 0;
        chk("postrst_data", u_dout, 128'h00000004_00000003_00000002_00000001);
        chk("postrst_keep", 128'(u_keep), 128'(4'hF));

        // Clean start for randomized traffic
        rst_n = 1'b0; #2 rst_n = 1'b1;
        uq.delete(); upend.delete(); dq.delete();
        for (int c = 0; c < 600; c++) begin
            fill   = ((c / 100) % 2) == 0;
            u_wv   = $urandom_range(0, 3) != 0;
            u_din  = $urandom;
            u_last = $urandom_range(0, 5) == 0;
            u_rv   = fill ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            d_wv   = fill ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
            d_rv   = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
            d_din  = {$urandom, $urandom, $urandom, $urandom};
            d_last = $urandom_range(0, 1) == 0;
            uwa = u_wv && (uq.size() < 8);
            ura = u_rv && (uq.size() > 0);
            dwa = d_wv && (((dq.size() + 3) / 4) < 8);
            dra = d_rv && (dq.size() > 0);
            tick();
            if (ura) void'(uq.pop_front());
            if (uwa) begin
                upend.push_back(u_din);
                if (upend.size() == 4 || u_last) begin
                    w.data = '0;
                    for (int k = 0; k < upend.size(); k++) w.data |= {96'h0, upend[k]} << (32 * k);
                    w.keep = 4'((1 << upend.size()) - 1);
                    w.last = u_last;
                    uq.push_back(w);
                    upend.delete();
                end
            end
            if (dra) void'(dq.pop_front());
            if (dwa) begin
                for (int k = 0; k < 4; k++) dq.push_back('{d_din[k*32 +: 32], d_last && (k == 3)});
            end
            chk_up();
            chk_dn();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
